// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: fun3 access codes, the MEM FSM state type and
// the byte-lane helpers used to build data-memory requests.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  // Unsigned variants exist only for loads; halves and words need natural alignment.
  function automatic logic legal_access(input logic [2:0] f3, input logic [1:0] off,
                                        input logic is_store);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return ~off[0];
      F3_W:    return (off == 2'b00);
      F3_BU:   return ~is_store;
      F3_HU:   return ~is_store & ~off[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load extension: aligns the addressed byte/half of a read word to bit 0 and
// sign- or zero-extends it according to fun3.
module load_extend
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  fun3,
  output logic [31:0] extended
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = rdata >> {offset, 3'b000};
    case (fun3)
      F3_B:    extended = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    extended = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   extended = {24'd0, w_shifted[7:0]};
      F3_HU:   extended = {16'd0, w_shifted[15:0]};
      default: extended = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues ready/valid data-memory transactions from EX/MEM,
// stalls upstream while the memory is busy and registers results into MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_MEM,
  input  logic [31:0] writedata_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic [2:0]  fun3_MEM,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic        memtoreg_MEM,
  input  logic        regwrite_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] alu_WB,
  output logic [31:0] memdata_WB,
  output logic [4:0]  rd_WB,
  output logic        memtoreg_WB,
  output logic        regwrite_WB,
  output logic        misalign_WB,
  output logic        timeout_WB
);

  localparam int             CW   = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0]  LAST = CW'(WAIT_LIMIT - 1);

  state_e        r_state;
  logic [CW-1:0] r_wait;
  logic [1:0]    r_off;

  logic        w_is_mem, w_legal, w_valid, w_done, w_tmo, w_load;
  logic [31:0] w_ext;

  assign w_is_mem = memread_MEM | memwrite_MEM;
  assign w_legal  = legal_access(fun3_MEM, alu_MEM[1:0], memwrite_MEM);
  assign w_valid  = w_is_mem & w_legal;
  assign w_load   = memread_MEM & ~memwrite_MEM;
  assign w_done   = (r_state == ACCESS) & dmem_ready;
  // Ready on the last allowed cycle wins over the timeout.
  assign w_tmo    = (r_state == ACCESS) & ~dmem_ready & (r_wait == LAST);

  assign mem_stall = ((r_state == IDLE) & w_valid) |
                     ((r_state == ACCESS) & ~w_done & ~w_tmo);

  // fun3 is stable from EX/MEM for the whole stall, so only the offset is latched.
  load_extend u_load_extend (
    .rdata    (dmem_rdata),
    .offset   (r_off),
    .fun3     (fun3_MEM),
    .extended (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_off       <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      alu_WB      <= '0;
      memdata_WB  <= '0;
      rd_WB       <= '0;
      memtoreg_WB <= 1'b0;
      regwrite_WB <= 1'b0;
      misalign_WB <= 1'b0;
      timeout_WB  <= 1'b0;
    end else begin
      alu_WB      <= '0;
      memdata_WB  <= '0;
      rd_WB       <= '0;
      memtoreg_WB <= 1'b0;
      regwrite_WB <= 1'b0;
      misalign_WB <= 1'b0;
      timeout_WB  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state    <= ACCESS;
            r_wait     <= '0;
            r_off      <= alu_MEM[1:0];
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite_MEM;
            dmem_addr  <= {alu_MEM[31:2], 2'b00};
            dmem_be    <= memwrite_MEM ? store_be(fun3_MEM, alu_MEM[1:0]) : 4'b1111;
            dmem_wdata <= lane_data(fun3_MEM, writedata_MEM);
          end else begin
            alu_WB      <= alu_MEM;
            rd_WB       <= rd_MEM;
            memtoreg_WB <= memtoreg_MEM & ~w_is_mem;
            regwrite_WB <= regwrite_MEM & ~w_is_mem;
            misalign_WB <= w_is_mem;
          end
        end
        ACCESS: begin
          if (w_done) begin
            r_state     <= IDLE;
            dmem_req    <= 1'b0;
            alu_WB      <= alu_MEM;
            rd_WB       <= rd_MEM;
            memtoreg_WB <= memtoreg_MEM;
            regwrite_WB <= regwrite_MEM;
            memdata_WB  <= w_load ? w_ext : 32'd0;
          end else if (w_tmo) begin
            r_state    <= IDLE;
            dmem_req   <= 1'b0;
            alu_WB     <= alu_MEM;
            rd_WB      <= rd_MEM;
            timeout_WB <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
